// File: rtl/imem_access_ctrl.sv
// imem_access_ctrl
//   Shares one single-port instruction memory between the IF-stage fetch port
//   (read-only) and the program-loader port (read/write). After reset the core
//   is held in BOOT, where only the loader may touch memory. A boot_done pulse
//   moves the block to RUN, where fetch has priority. A loader that has been
//   denied MAX_WAIT consecutive cycles wins the next contended cycle.
//   instr_count tracks the highest written word index + 1.
//
//   State table:
//     state  | meaning
//     S_BOOT | program load; fetch blocked, loader always granted
//     S_RUN  | normal operation; fetch priority with loader starvation bound
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   boot_done           loader pulse: program image complete
//   f_req/f_addr        fetch request, byte address
//   f_gnt               fetch accepted (combinational)
//   f_rvalid/f_rdata    fetch read return, one cycle after grant
//   f_err               qualifies f_rvalid: address was out of range
//   l_req/l_we/l_addr/l_wdata  loader request
//   l_gnt               loader accepted (combinational)
//   l_rvalid/l_rdata    loader read return, one cycle after grant
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port (1-cycle read)
//   running             registered, 1 while in RUN
//   instr_count         highest written word index + 1
module imem_access_ctrl #(
  parameter int DEPTH    = 1024,
  parameter int MAX_WAIT = 4,
  parameter int BOOT_EN  = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          boot_done,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          running,
  output logic [AW:0]   instr_count
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_BOOT, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [WW-1:0] wait_cnt;
  logic          f_inr, l_inr;
  logic          f_pend, f_pend_oor;
  logic          l_pend, l_pend_oor;
  logic [AW:0]   l_wr_next;

  assign f_inr = (f_addr[31:2] < 30'(DEPTH));
  assign l_inr = (l_addr[31:2] < 30'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= (BOOT_EN != 0) ? S_BOOT : S_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Grants are forced low while reset is asserted so every output reads 0.
  always_comb begin
    state_nxt = state;
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    if (rst) begin
      case (state)
        S_BOOT: begin
          l_gnt = l_req;
          if (boot_done) state_nxt = S_RUN;
        end
        S_RUN: begin
          if (f_req && l_req) begin
            if (wait_cnt == WW'(MAX_WAIT)) l_gnt = 1'b1;
            else                           f_gnt = 1'b1;
          end else begin
            f_gnt = f_req;
            l_gnt = l_req;
          end
        end
        default: state_nxt = S_BOOT;
      endcase
    end
  end

  // Out-of-range accesses are granted but never reach the memory.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (f_gnt) begin
      mem_en = f_inr;
      if (f_inr) mem_addr = f_addr[AW+1:2];
    end else if (l_gnt) begin
      mem_en = l_inr;
      if (l_inr) begin
        mem_we   = l_we;
        mem_addr = l_addr[AW+1:2];
        if (l_we) mem_wdata = l_wdata;
      end
    end
  end

  assign l_wr_next = {1'b0, l_addr[AW+1:2]} + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_pend      <= 1'b0;
      f_pend_oor  <= 1'b0;
      l_pend      <= 1'b0;
      l_pend_oor  <= 1'b0;
      wait_cnt    <= '0;
      instr_count <= '0;
      running     <= 1'b0;
    end else begin
      f_pend     <= f_gnt;
      f_pend_oor <= f_gnt && !f_inr;
      l_pend     <= l_gnt && !l_we;
      l_pend_oor <= l_gnt && !l_we && !l_inr;
      running    <= (state_nxt == S_RUN);
      if (l_req && !l_gnt) begin
        if (wait_cnt != WW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (l_gnt && l_we && l_inr && (l_wr_next > instr_count)) begin
        instr_count <= l_wr_next;
      end
    end
  end

  assign f_rvalid = f_pend;
  assign f_err    = f_pend_oor;
  assign f_rdata  = (f_pend && !f_pend_oor) ? mem_rdata : 32'h0;
  assign l_rvalid = l_pend;
  assign l_rdata  = (l_pend && !l_pend_oor) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// tb_imem_access_ctrl
//   Directed bench for imem_access_ctrl with a 1-cycle synchronous memory
//   model. Expected read returns are queued when a grant is seen and checked
//   when rvalid should appear; grant/address/count values are checked inline.
module tb_imem_access_ctrl;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          boot_done = 1'b0;
  logic          f_req = 1'b0;
  logic [31:0]   f_addr = '0;
  logic          f_gnt, f_rvalid, f_err;
  logic [31:0]   f_rdata;
  logic          l_req = 1'b0, l_we = 1'b0;
  logic [31:0]   l_addr = '0, l_wdata = '0;
  logic          l_gnt, l_rvalid;
  logic [31:0]   l_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          running;
  logic [AW:0]   instr_count;

  imem_access_ctrl #(.DEPTH(DEPTH), .MAX_WAIT(4), .BOOT_EN(1)) dut (
    .clk(clk), .rst(rst), .boot_done(boot_done),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .running(running), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t fq[$];
  exp_t lq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record expected read returns for whatever was granted this cycle.
  task automatic note();
    exp_t e;
    int unsigned idx;
    if (f_req && f_gnt) begin
      idx = f_addr[31:2];
      e.err  = (idx >= DEPTH);
      e.data = (idx < DEPTH) ? ref_mem[idx] : 32'h0;
      fq.push_back(e);
    end
    if (l_req && l_gnt) begin
      idx = l_addr[31:2];
      if (l_we) begin
        if (idx < DEPTH) ref_mem[idx] = l_wdata;
      end else begin
        e.err  = 1'b0;
        e.data = (idx < DEPTH) ? ref_mem[idx] : 32'h0;
        lq.push_back(e);
      end
    end
  endtask

  // Advance one cycle and check read returns against the scoreboard.
  task automatic cyc();
    exp_t e;
    @(posedge clk); #1;
    chk("f_rvalid", f_rvalid, fq.size() > 0);
    if (fq.size() > 0) begin
      e = fq.pop_front();
      chk("f_rdata", f_rdata, e.data);
      chk("f_err", f_err, e.err);
    end
    chk("l_rvalid", l_rvalid, lq.size() > 0);
    if (lq.size() > 0) begin
      e = lq.pop_front();
      chk("l_rdata", l_rdata, e.data);
    end
  endtask

  task automatic lwrite(input logic [31:0] a, input logic [31:0] d);
    l_req = 1'b1; l_we = 1'b1; l_addr = a; l_wdata = d;
    #1;
    chk("lw_gnt", l_gnt, 1'b1);
    note();
    cyc();
    l_req = 1'b0; l_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end

    // reset: requests present but every output must stay 0
    f_req = 1'b1; l_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_f_gnt", f_gnt, 1'b0);
    chk("rst_l_gnt", l_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_running", running, 1'b0);
    chk("rst_icount", instr_count, 11'd0);
    chk("rst_f_rvalid", f_rvalid, 1'b0);
    f_req = 1'b0; l_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    cyc();

    // BOOT: fetch held off while the program is loaded
    f_req = 1'b1; f_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      l_req = 1'b1; l_we = 1'b1; l_addr = 32'(i * 4);
      l_wdata = (i == 0) ? 32'h002082B3 : (i == 1) ? 32'h005182B3 : 32'h005202B3;
      #1;
      chk("boot_f_gnt", f_gnt, 1'b0);
      chk("boot_l_gnt", l_gnt, 1'b1);
      chk("boot_mem_addr", mem_addr, 10'(i));
      chk("boot_mem_we", mem_we, 1'b1);
      note();
      cyc();
    end
    l_req = 1'b0; l_we = 1'b0;
    #1;
    chk("boot_icount", instr_count, 11'd3);
    boot_done = 1'b1;
    #1;
    chk("bd_f_gnt", f_gnt, 1'b0);
    chk("bd_running", running, 1'b0);
    note();
    cyc();
    boot_done = 1'b0;
    #1;
    chk("run_running", running, 1'b1);
    chk("run_f_gnt", f_gnt, 1'b1);
    note();
    cyc();

    // RUN fetch @0x8
    f_addr = 32'h8;
    #1;
    chk("f8_gnt", f_gnt, 1'b1);
    chk("f8_mem_addr", mem_addr, 10'd2);
    chk("f8_mem_we", mem_we, 1'b0);
    chk("f8_mem_en", mem_en, 1'b1);
    note();
    cyc();

    // contention: loader read starved for exactly 4 cycles
    f_addr = 32'h0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h4;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ct_l_gnt_lo", l_gnt, 1'b0);
      chk("ct_f_gnt_hi", f_gnt, 1'b1);
      note();
      cyc();
    end
    #1;
    chk("ct_l_gnt_hi", l_gnt, 1'b1);
    chk("ct_f_gnt_lo", f_gnt, 1'b0);
    chk("ct_mem_addr", mem_addr, 10'd1);
    note();
    cyc();
    l_req = 1'b0;
    #1;
    chk("ct_f_regain", f_gnt, 1'b1);
    note();
    cyc();

    // out-of-range fetch, then ignored low address bits
    f_addr = 32'h1000;
    #1;
    chk("oor_f_gnt", f_gnt, 1'b1);
    chk("oor_mem_en", mem_en, 1'b0);
    note();
    cyc();
    f_addr = 32'h6;
    #1;
    chk("f6_mem_addr", mem_addr, 10'd1);
    note();
    cyc();
    f_req = 1'b0;

    // out-of-range loader read and write
    l_req = 1'b1; l_we = 1'b0; l_addr = 32'h1000;
    #1;
    chk("loor_gnt", l_gnt, 1'b1);
    chk("loor_mem_en", mem_en, 1'b0);
    note();
    cyc();
    l_we = 1'b1; l_addr = 32'h2000; l_wdata = 32'hDEADBEEF;
    #1;
    chk("loorw_mem_en", mem_en, 1'b0);
    chk("loorw_mem_we", mem_we, 1'b0);
    note();
    cyc();
    l_req = 1'b0; l_we = 1'b0;
    chk("loorw_icount", instr_count, 11'd3);

    // out-of-order writes never shrink instr_count; top word reaches DEPTH
    lwrite(32'h14, 32'h11111111);
    chk("ooo_icount6", instr_count, 11'd6);
    lwrite(32'h8, 32'h22222222);
    chk("ooo_icount_keep", instr_count, 11'd6);
    lwrite(32'hFFC, 32'h33333333);
    chk("top_icount", instr_count, 11'd1024);

    // read back rewritten word through fetch
    f_req = 1'b1; f_addr = 32'h8;
    #1;
    note();
    cyc();

    // reset while a granted fetch is outstanding
    f_addr = 32'h0;
    #1;
    chk("rs_f_gnt", f_gnt, 1'b1);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rs_gnt_in_rst", f_gnt, 1'b0);
    @(posedge clk); #1;
    chk("rs_f_rvalid", f_rvalid, 1'b0);
    chk("rs_running", running, 1'b0);
    chk("rs_icount", instr_count, 11'd0);
    @(negedge clk); rst = 1'b1;
    cyc();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h0; l_wdata = 32'h002082B3;
    #1;
    chk("rs_boot_f_gnt", f_gnt, 1'b0);
    chk("rs_boot_l_gnt", l_gnt, 1'b1);
    note();
    cyc();
    l_req = 1'b0; l_we = 1'b0; f_req = 1'b0;
    chk("rs_icount1", instr_count, 11'd1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
